// File: rtl/sel_decode_pk.sv
// Binary-to-one-hot select decoder for the shared-memory mux, with a dwell
// window after each accepted select and an out-of-range error pulse.
module sel_decode_pk #(
   parameter  int N         = 8,
   parameter  int HOLD      = 2,
   localparam int WIDTH_SEL = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH_SEL-1:0] in_sel,
   input  logic                 release_sel,
   output logic [N-1:0]         out_new,
   output logic [N-1:0]         out_old,
   output logic                 out_valid,
   output logic                 change,
   output logic                 err
);

   localparam int CW = (HOLD > 0) ? $clog2(HOLD + 1) : 1;

   typedef enum logic {ST_IDLE, ST_HOLD} state_t;

   state_t         state, state_nx;
   logic [CW-1:0]  cnt, cnt_nx;
   logic           accept, sel_ok;
   logic [N-1:0]   dec;

   // release wins over any request in the same cycle
   assign in_ready = (state == ST_IDLE) && !release_sel;
   assign accept   = in_valid && in_ready;
   assign sel_ok   = 32'(in_sel) < N;

   always_comb begin
      dec = '0;
      for (int i = 0; i < N; i++)
         if (in_sel == WIDTH_SEL'(i)) dec[i] = 1'b1;
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      if (release_sel) begin
         state_nx = ST_IDLE;
         cnt_nx   = '0;
      end else begin
         case (state)
            ST_IDLE:
               if (accept && sel_ok && (HOLD > 0)) begin
                  state_nx = ST_HOLD;
                  cnt_nx   = CW'(HOLD);
               end
            ST_HOLD:
               if (cnt <= CW'(1)) begin
                  state_nx = ST_IDLE;
                  cnt_nx   = '0;
               end else begin
                  cnt_nx = cnt - CW'(1);
               end
            default: begin
               state_nx = ST_IDLE;
               cnt_nx   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_new   <= '0;
         out_old   <= '0;
         out_valid <= 1'b0;
         change    <= 1'b0;
         err       <= 1'b0;
      end else begin
         change <= 1'b0;
         err    <= 1'b0;
         if (release_sel) begin
            if (out_valid) begin
               out_old   <= out_new;
               out_new   <= '0;
               out_valid <= 1'b0;
            end
         end else if (accept) begin
            if (sel_ok) begin
               out_old   <= out_new;
               out_new   <= dec;
               out_valid <= 1'b1;
               change    <= (dec != out_new);
            end else begin
               err <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_sel_decode_pk.sv
// Drives three decoder builds (N=8/HOLD=2, N=6/HOLD=2, N=8/HOLD=0) with shared
// stimulus and compares each against a per-build transaction-level model.
module tb_sel_decode_pk;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b1, in_valid = 1'b0, rls = 1'b0;
   logic [2:0] in_sel = '0;

   logic       rdy[3], gval[3], gchg[3], gerr[3];
   logic [7:0] gnew[3], gold[3];
   logic [5:0] b_new, b_old;

   assign gnew[1] = {2'b00, b_new};
   assign gold[1] = {2'b00, b_old};

   sel_decode_pk #(.N(8), .HOLD(2)) dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .in_sel(in_sel),
      .release_sel(rls), .out_new(gnew[0]), .out_old(gold[0]), .out_valid(gval[0]),
      .change(gchg[0]), .err(gerr[0]));

   sel_decode_pk #(.N(6), .HOLD(2)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .in_sel(in_sel),
      .release_sel(rls), .out_new(b_new), .out_old(b_old), .out_valid(gval[1]),
      .change(gchg[1]), .err(gerr[1]));

   sel_decode_pk #(.N(8), .HOLD(0)) dut_c (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .in_sel(in_sel),
      .release_sel(rls), .out_new(gnew[2]), .out_old(gold[2]), .out_valid(gval[2]),
      .change(gchg[2]), .err(gerr[2]));

   typedef struct {
      int nw, od;
      bit vl, ch, er;
      int dw;   // cycles of dwell still to run
   } mdl_t;

   int   NS[3] = '{8, 6, 8};
   int   HS[3] = '{2, 2, 0};
   mdl_t m[3];
   int   errs = 0, checks = 0;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic mdl_t step(mdl_t s0, int n, int hold, bit r, bit v, int s, bit rl);
      mdl_t q = s0;
      if (r) begin
         q = '{default: 0};
         return q;
      end
      q.ch = 0;
      q.er = 0;
      if (rl) begin
         if (s0.vl) begin
            q.od = s0.nw;
            q.nw = 0;
            q.vl = 0;
         end
         q.dw = 0;
      end else begin
         if (s0.dw > 0) q.dw = s0.dw - 1;
         if (v && s0.dw == 0) begin
            if (s < n) begin
               q.od = s0.nw;
               q.nw = 1 << s;
               q.vl = 1;
               q.ch = (s0.nw != (1 << s));
               q.dw = hold;
            end else begin
               q.er = 1;
            end
         end
      end
      return q;
   endfunction

   task automatic cyc(bit r, bit v, int s, bit rl);
      @(negedge clk);
      rst = r; in_valid = v; in_sel = s[2:0]; rls = rl;
      #1;
      for (int k = 0; k < 3; k++)
         chk($sformatf("d%0d.ready", k), rdy[k], (m[k].dw == 0) && !rl);
      @(posedge clk);
      for (int k = 0; k < 3; k++) m[k] = step(m[k], NS[k], HS[k], r, v, s, rl);
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("d%0d.new", k),   gnew[k], m[k].nw);
         chk($sformatf("d%0d.old", k),   gold[k], m[k].od);
         chk($sformatf("d%0d.valid", k), gval[k], m[k].vl);
         chk($sformatf("d%0d.change", k), gchg[k], m[k].ch);
         chk($sformatf("d%0d.err", k),   gerr[k], m[k].er);
      end
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
   endtask

   initial begin
      for (int k = 0; k < 3; k++) m[k] = '{default: 0};
      repeat (2) @(posedge clk);

      // reset
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      idle(1);
      chk("reset.ready", rdy[0], 1'b1);
      chk("reset.new", gnew[0], 8'h00);

      // sweep with in_valid held through each dwell
      for (int s = 0; s < 8; s++)
         for (int j = 0; j < 3; j++) cyc(0, 1, s, 0);
      chk("sweep.new", gnew[0], 8'h80);
      chk("sweep.old", gold[0], 8'h40);

      // same index re-selected
      idle(3);
      cyc(0, 1, 3, 0);
      idle(2);
      cyc(0, 1, 3, 0);
      chk("same.new", gnew[0], 8'h08);
      chk("same.old", gold[0], 8'h08);
      chk("same.change", gchg[0], 1'b0);
      idle(2);

      // out of range on the N=6 build
      idle(1);
      cyc(0, 1, 2, 0);
      idle(2);
      cyc(0, 1, 7, 0);
      chk("oor.err", gerr[1], 1'b1);
      chk("oor.new", gnew[1], 8'h04);
      cyc(0, 0, 0, 0);
      chk("oor.err_clr", gerr[1], 1'b0);

      // release priority
      idle(3);
      cyc(0, 1, 5, 0);
      cyc(0, 1, 1, 1);
      chk("rel.new", gnew[0], 8'h00);
      chk("rel.old", gold[0], 8'h20);
      chk("rel.valid", gval[0], 1'b0);
      cyc(0, 1, 1, 0);
      chk("rel.next", gnew[0], 8'h02);
      chk("rel.change", gchg[0], 1'b1);

      // reset in the first dwell cycle
      idle(3);
      cyc(0, 1, 4, 0);
      cyc(1, 1, 4, 0);
      cyc(0, 0, 0, 0);
      chk("rstmid.new", gnew[0], 8'h00);

      // back-to-back on the HOLD=0 build
      idle(3);
      cyc(0, 1, 1, 0);
      chk("h0.a", gnew[2], 8'h02);
      cyc(0, 1, 2, 0);
      chk("h0.b", gnew[2], 8'h04);
      cyc(0, 1, 3, 0);
      chk("h0.c", gnew[2], 8'h08);

      // random traffic
      repeat (500)
         cyc(($urandom % 40) == 0, ($urandom % 4) != 0,
             int'($urandom_range(0, 7)), ($urandom % 8) == 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/sel_decode_pk.md
Name: sel_decode_pk

Overview:
- Binary-to-one-hot select decoder for the shared-memory mux control. It is the counterpart of the one-hot-to-index encoder.
- Accepts a port index over a valid/ready handshake and produces a registered one-hot mux select (`out_new`) plus the previous select (`out_old`).
- Enforces a minimum dwell time so the mux is not re-steered while a transfer is settling.
- Flags out-of-range indices.

Parameters:
- N, 8 (normally `PORT_NUB_TOTAL), number of ports / one-hot width; N >= 2.
- WIDTH_SEL, $clog2(N), index width; derived, not overridden.
- HOLD, 2, dwell cycles after an accepted select during which no new select is accepted; 0 = no dwell.

Ports:
- clk  in  1  clock. One clock domain.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  index valid.
- in_ready  out  1  decoder can accept an index.
- in_sel  in  WIDTH_SEL  requested port index.
- release  in  1  single-cycle pulse; drops the current select.
- out_new  out  N  current one-hot select; zero when none.
- out_old  out  N  select value held before the last update.
- out_valid  out  1  out_new holds a live select.
- change  out  1  one-cycle pulse; out_new changed to a different non-zero value.
- err  out  1  one-cycle pulse; index >= N was presented and accepted.

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_new=0, out_old=0, out_valid=0, change=0, err=0.
  - State IDLE, dwell counter 0, so in_ready=1 after reset (unless release=1).
  - Reset mid-dwell aborts the dwell immediately.
- States: IDLE, HOLD.
- in_ready is combinational: in_ready = (state==IDLE) && !release.
- Accept: in_valid && in_ready at edge t.
  - Valid index (in_sel < N), visible in cycle t+1:
    - out_new = 1<<in_sel; out_old = out_new before t; out_valid=1.
    - change=1 iff the new out_new differs from the old out_new. It also pulses when the old value was 0. It stays 0 when the same index is re-selected.
    - If HOLD>0: state goes to HOLD with counter=HOLD, and in_ready=0 during cycles t+1..t+HOLD.
    - If HOLD=0: stays in IDLE.
  - Out-of-range index (in_sel >= N):
    - err=1 in cycle t+1.
    - out_new, out_old, out_valid unchanged; change=0.
    - No dwell; stays in IDLE.
- HOLD: counter decrements each cycle. The cycle in which counter==1 transitions to IDLE, so in_ready returns at t+HOLD+1.
- release=1 at edge t (priority over accept; in_ready is forced 0 that cycle, so nothing is accepted):
  - If out_valid: out_old = out_new, out_new = 0, out_valid = 0, change = 0.
  - Any state: state goes to IDLE, counter = 0. This aborts a dwell.
  - release while out_valid=0: no output change; only a dwell abort if one is pending.
- in_valid held high while in_ready=0: the request waits and is accepted on the first in_ready cycle. in_sel must be held stable by the source; the decoder does not latch it early.
- change and err are single-cycle pulses, cleared on the next edge unless re-triggered by another accept.
- Latency: one cycle from accept edge to outputs.
- No combinational path from in_sel to any output.

Test Plan (N=8, HOLD=2 unless noted):
- Reset: rst=1 for 2 cycles, then 0 → out_new=0, out_old=0, out_valid=0, change=0, err=0, in_ready=1.
- Sweep: present in_sel=0..7, each accepted when in_ready=1.
  - Each accept gives out_new=8'h01,8'h02,…,8'h80 one cycle later.
  - out_old equals the previous out_new, starting at 0.
  - change=1 on every accept.
  - in_ready low exactly 2 cycles after each accept.
- Same index: accept 3, wait for dwell, accept 3 again → out_new=8'h08, out_old=8'h08, change=0, dwell restarts.
- Out of range: build with N=6, accept in_sel=7 → err=1 for one cycle; out_new keeps its prior value 8'h... (e.g. 6'h04 from a prior sel 2); in_ready stays 1 the next cycle.
- Release priority: accept 5, then one cycle later assert release with in_valid=1, in_sel=1.
  - in_ready=0 in that cycle; out_new becomes 0, out_old=8'h20, out_valid=0.
  - Dwell is aborted; sel 1 is accepted on the next cycle, giving out_new=8'h02 and change=1.
- Reset mid-dwell: accept 4, assert rst in the first dwell cycle → all outputs return to 0 and in_ready=1 right after rst deasserts.
- HOLD=0 build: back-to-back accepts 1, 2, 3 on consecutive cycles → out_new=8'h02, 8'h04, 8'h08 on consecutive cycles; in_ready stays 1.
